// File: rtl/expr_paren_checker_pkg.sv
// expr_pkg: state encoding, character classes and ASCII constants
// shared by the expression recogniser and its character classifier.
package expr_pkg;
    typedef enum logic [1:0] {EXP, NUM, AFT, ERR} state_t;
    typedef enum logic [2:0] {C_DIG, C_OP, C_LP, C_RP, C_SP, C_BAD} cls_t;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_SP    = 8'h20;
endpackage

// File: rtl/expr_paren_checker_char_class.sv
// expr_char_class: maps an ASCII character to its lexical class; optional
// operators and the space separator fall to C_BAD when disabled.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_SUBDIV = 1,
    parameter int ALLOW_SPACE  = 1
) (
    input  logic [7:0] ch,
    output cls_t       cls
);
    logic is_op;
    assign is_op = (ch == CH_PLUS) || (ch == CH_MUL) ||
                   ((ALLOW_SUBDIV != 0) && ((ch == CH_MINUS) || (ch == CH_DIV)));
    always_comb begin
        cls = (ch >= CH_0 && ch <= CH_9)               ? C_DIG :
              is_op                                   ? C_OP  :
              (ch == CH_LP)                           ? C_LP  :
              (ch == CH_RP)                           ? C_RP  :
              ((ALLOW_SPACE != 0) && (ch == CH_SP))   ? C_SP  : C_BAD;
    end
endmodule

// File: rtl/expr_paren_checker.sv
// expr_paren_checker: streaming recogniser flagging when the characters seen
// since the last clear/restart form a complete, well-formed expression.
module expr_paren_checker
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS   = 8,
    parameter int MAX_DEPTH    = 4,
    parameter int ALLOW_SUBDIV = 1,
    parameter int ALLOW_SPACE  = 1
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           in_valid,
    input  logic [7:0]                     in,
    input  logic                           restart,
    output logic                           out,
    output logic                           err,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    state_t        state;
    cls_t          cls;
    logic [CW-1:0] dcnt;
    expr_char_class #(.ALLOW_SUBDIV(ALLOW_SUBDIV), .ALLOW_SPACE(ALLOW_SPACE)) u_class (
        .ch (in),
        .cls(cls)
    );
    // Counters are checked before they move, so neither can wrap; ERR freezes them.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= EXP;
            depth <= '0;
            dcnt  <= '0;
        end else if (restart) begin
            state <= EXP;
            depth <= '0;
            dcnt  <= '0;
        end else if (in_valid) begin
            case (state)
                EXP: case (cls)
                    C_DIG: begin
                        state <= NUM;
                        dcnt  <= CW'(1);
                    end
                    C_LP: if (depth == DW'(MAX_DEPTH)) state <= ERR;
                          else depth <= depth + 1'b1;
                    C_SP: state <= EXP;
                    default: state <= ERR;
                endcase
                NUM: case (cls)
                    C_DIG: if (dcnt == CW'(MAX_DIGITS)) state <= ERR;
                           else dcnt <= dcnt + 1'b1;
                    C_OP: state <= EXP;
                    C_SP: state <= AFT;
                    C_RP: if (depth == '0) state <= ERR;
                          else begin
                              state <= AFT;
                              depth <= depth - 1'b1;
                          end
                    default: state <= ERR;
                endcase
                AFT: case (cls)
                    C_OP: state <= EXP;
                    C_SP: state <= AFT;
                    C_RP: if (depth == '0) state <= ERR;
                          else depth <= depth - 1'b1;
                    default: state <= ERR;
                endcase
                default: state <= ERR;
            endcase
        end
    end
    assign out = ((state == NUM) || (state == AFT)) && (depth == '0);
    assign err = (state == ERR);
endmodule

// File: tb/tb_expr_paren_checker.sv
// tb_expr_paren_checker: directed checks of a default instance (a) and a
// MAX_DEPTH=2, ALLOW_SUBDIV=0 instance (b) driven by the same character stream.
module tb_expr_paren_checker;
    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;
    logic       restart = 1'b0;
    logic       out_a, err_a, out_b, err_b;
    logic [2:0] depth_a;
    logic [1:0] depth_b;
    int         tests = 0;
    int         fails = 0;

    expr_paren_checker dut_a (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in), .restart(restart),
        .out(out_a), .err(err_a), .depth(depth_a)
    );
    expr_paren_checker #(.MAX_DIGITS(8), .MAX_DEPTH(2), .ALLOW_SUBDIV(0), .ALLOW_SPACE(1)) dut_b (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(in), .restart(restart),
        .out(out_b), .err(err_b), .depth(depth_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        in = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in = ")";
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // A valid '(' alongside restart must be discarded.
    task automatic do_restart(input string tag);
        restart = 1'b1;
        send("(");
        restart = 1'b0;
        chk({tag, "_rst_out"}, {7'b0, out_a}, 8'd0);
        chk({tag, "_rst_err"}, {7'b0, err_a}, 8'd0);
        chk({tag, "_rst_depth"}, {5'b0, depth_a}, 8'd0);
        chk({tag, "_rst_err_b"}, {7'b0, err_b}, 8'd0);
    endtask

    // Expectation strings hold one digit per character; empty B strings skip instance b.
    task automatic run(input string tag, input string s, input string eo, input string ed,
                       input string ee, input string ebd, input string ebe);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("%s[%0d]_out", tag, i), {7'b0, out_a}, eo[i] - 8'h30);
            chk($sformatf("%s[%0d]_depth", tag, i), {5'b0, depth_a}, ed[i] - 8'h30);
            chk($sformatf("%s[%0d]_err", tag, i), {7'b0, err_a}, ee[i] - 8'h30);
            if (ebe.len() > 0) begin
                chk($sformatf("%s[%0d]_depth_b", tag, i), {6'b0, depth_b}, ebd[i] - 8'h30);
                chk($sformatf("%s[%0d]_err_b", tag, i), {7'b0, err_b}, ebe[i] - 8'h30);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_out", {7'b0, out_a}, 8'd0);
        chk("reset_err", {7'b0, err_a}, 8'd0);
        chk("reset_depth", {5'b0, depth_a}, 8'd0);
        clr_n = 1'b1;
        @(negedge clk);

        run("sum", "12+3", "1101", "0000", "0000", "", "");
        do_restart("sum");

        run("nest", "(1+(2*3))", "000000001", "111222210", "000000000", "", "");
        do_restart("nest");

        run("digits", "123456789", "111111110", "000000000", "000000001", "", "");
        do_restart("digits");

        run("badrp", "1+)", "100", "000", "001", "", "");
        run("sticky", "5", "0", "0", "1", "", "");
        #2 clr_n = 1'b0;
        #1 chk("async_err", {7'b0, err_a}, 8'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run("seven", "7", "1", "0", "0", "", "");
        #2 clr_n = 1'b0;
        #1 chk("async_out", {7'b0, out_a}, 8'd0);
        chk("async_depth", {5'b0, depth_a}, 8'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        run("under", "1)", "10", "00", "01", "", "");
        do_restart("under");

        run("deep", "(((", "000", "123", "000", "122", "001");
        do_restart("deep");

        run("subdiv", "4 - 2", "11001", "00000", "00000", "00000", "00111");
        do_restart("subdiv");

        run("space", "4 2", "110", "000", "001", "", "");
        do_restart("space");

        send("1");
        idle(3);
        chk("gap1_out", {7'b0, out_a}, 8'd1);
        chk("gap1_depth", {5'b0, depth_a}, 8'd0);
        send("+");
        idle(2);
        chk("gap2_out", {7'b0, out_a}, 8'd0);
        chk("gap2_err", {7'b0, err_a}, 8'd0);
        send("2");
        chk("gap3_out", {7'b0, out_a}, 8'd1);
        chk("gap3_err", {7'b0, err_a}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
